// File: rtl/i2c_target.sv
// I2C register-map target: oversampled SCL/SDA, open-drain SDA drive,
// write strobe per received data byte and a pointer-addressed read port.
module i2c_target #(
  parameter logic [6:0] DEVICE = 7'h39
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DEV  = 3'd1;
  localparam logic [2:0] ST_REG  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_RD   = 3'd4;

  logic [1:0] scl_sync_reg, sda_sync_reg;
  logic       scl_prev_reg, sda_prev_reg;
  logic       s_scl, s_sda;
  logic       scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] state_reg;
  logic [3:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [7:0] ptr_reg;
  logic       ack_pend_reg;
  logic       rw_reg;
  logic [7:0] byte_in;

  // Synchronizers idle high so that reset release never looks like a START
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], scl_i};
      sda_sync_reg <= {sda_sync_reg[0], sda_i};
      scl_prev_reg <= scl_sync_reg[1];
      sda_prev_reg <= sda_sync_reg[1];
    end
  end

  assign s_scl     = scl_sync_reg[1];
  assign s_sda     = sda_sync_reg[1];
  assign scl_rise  = s_scl & ~scl_prev_reg;
  assign scl_fall  = ~s_scl & scl_prev_reg;
  assign start_det = s_scl & scl_prev_reg & sda_prev_reg & ~s_sda;
  assign stop_det  = s_scl & scl_prev_reg & ~sda_prev_reg & s_sda;
  assign byte_in   = {shift_reg[6:0], s_sda};
  assign rd_addr   = ptr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'h00;
      ptr_reg      <= 8'h00;
      ack_pend_reg <= 1'b0;
      rw_reg       <= 1'b0;
      sda_oe       <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= 8'h00;
      wr_data      <= 8'h00;
      busy         <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      if (start_det || stop_det) begin
        state_reg    <= start_det ? ST_DEV : ST_IDLE;
        bit_cnt_reg  <= 4'd0;
        ack_pend_reg <= 1'b0;
        busy         <= 1'b0;
        sda_oe       <= 1'b0;
      end else if (state_reg != ST_IDLE) begin
        if (scl_rise) begin
          if (bit_cnt_reg != 4'd8) begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (state_reg != ST_RD)
              shift_reg <= byte_in;
          end
          // 8th rising edge: a full byte has arrived from the master
          if (bit_cnt_reg == 4'd7) begin
            case (state_reg)
              ST_DEV: begin
                ack_pend_reg <= (byte_in[7:1] == DEVICE);
                busy         <= (byte_in[7:1] == DEVICE);
                rw_reg       <= byte_in[0];
              end
              ST_REG: begin
                ptr_reg      <= byte_in;
                ack_pend_reg <= 1'b1;
              end
              ST_WR: begin
                wr_valid     <= 1'b1;
                wr_addr      <= ptr_reg;
                wr_data      <= byte_in;
                ptr_reg      <= ptr_reg + 8'd1;
                ack_pend_reg <= 1'b1;
              end
              default: ;
            endcase
          end
          // 9th rising edge: ACK slot closes
          if (bit_cnt_reg == 4'd8) begin
            bit_cnt_reg  <= 4'd0;
            ack_pend_reg <= 1'b0;
            case (state_reg)
              ST_DEV:  state_reg <= ack_pend_reg ? (rw_reg ? ST_RD : ST_REG) : ST_IDLE;
              ST_REG:  state_reg <= ST_WR;
              ST_RD: begin
                ptr_reg <= ptr_reg + 8'd1;
                if (s_sda) begin
                  state_reg <= ST_IDLE;
                  busy      <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end else if (scl_fall) begin
          if (state_reg == ST_RD) begin
            if (bit_cnt_reg == 4'd0) begin
              shift_reg <= rd_data;
              sda_oe    <= ~rd_data[7];
            end else if (bit_cnt_reg == 4'd8) begin
              sda_oe <= 1'b0;
            end else begin
              shift_reg <= {shift_reg[6:0], 1'b0};
              sda_oe    <= ~shift_reg[6];
            end
          end else begin
            sda_oe <= (bit_cnt_reg == 4'd8) && ack_pend_reg;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged master drives SCL/SDA and a
// registered register-file model answers reads.
module tb_i2c_target;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i, sda_i;
  logic       sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data = 8'h00;

  int n_checks = 0;
  int n_fail = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  logic [15:0] wq[$];

  always #5 clk = ~clk;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  i2c_target #(.DEVICE(7'h39)) dut (
    .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always @(posedge clk) begin
    case (rd_addr)
      8'h98:   rd_data <= 8'h03;
      8'h99:   rd_data <= 8'h5A;
      default: rd_data <= 8'hD5;
    endcase
  end

  always @(negedge clk) begin
    if (wr_valid) wq.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      sda_m = b[i]; tick(Q);
      scl_m = 1'b1; tick(2*Q);
      scl_m = 1'b0; tick(Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = ~sda_i; tick(Q);
    scl_m = 1'b0; tick(Q);
    $display("write byte %02h ack=%0b", b, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] data);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(Q);
      scl_m = 1'b1; tick(Q);
      data[i] = sda_i; tick(Q);
      scl_m = 1'b0;
    end
    sda_m = nack; tick(Q);
    scl_m = 1'b1; tick(2*Q);
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b1;
    $display("read byte %02h nack=%0b", data, nack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int base, oe_base, busy_base;

    tick(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick(4);

    // 1: single register write
    base = wq.size();
    i2c_start();
    write_byte(8'h72, ack); check("t1_ack_dev", ack, 1);
    check("t1_busy", busy, 1);
    write_byte(8'h41, ack); check("t1_ack_reg", ack, 1);
    write_byte(8'h10, ack); check("t1_ack_data", ack, 1);
    i2c_stop(); tick(4);
    check("t1_wr_count", wq.size() - base, 1);
    if (wq.size() > base) check("t1_wr0", wq[base], 16'h4110);
    check("t1_rd_addr", rd_addr, 8'h42);
    check("t1_busy_end", busy, 0);
    check("t1_sda_oe_end", sda_oe, 0);

    // 2: burst write with pointer wrap
    base = wq.size();
    i2c_start();
    write_byte(8'h72, ack); check("t2_ack_dev", ack, 1);
    write_byte(8'hFE, ack); check("t2_ack_reg", ack, 1);
    write_byte(8'hAA, ack); check("t2_ack_d0", ack, 1);
    write_byte(8'hBB, ack); check("t2_ack_d1", ack, 1);
    write_byte(8'hCC, ack); check("t2_ack_d2", ack, 1);
    i2c_stop(); tick(4);
    check("t2_wr_count", wq.size() - base, 3);
    if (wq.size() >= base + 3) begin
      check("t2_wr0", wq[base], 16'hFEAA);
      check("t2_wr1", wq[base+1], 16'hFFBB);
      check("t2_wr2", wq[base+2], 16'h00CC);
    end
    check("t2_rd_addr", rd_addr, 8'h01);

    // 3: wrong device address is ignored
    base = wq.size(); oe_base = oe_cnt; busy_base = busy_cnt;
    i2c_start();
    write_byte(8'h70, ack); check("t3_nack_dev", ack, 0);
    write_byte(8'h41, ack);
    write_byte(8'h10, ack);
    i2c_stop(); tick(4);
    check("t3_sda_oe_seen", oe_cnt - oe_base, 0);
    check("t3_busy_seen", busy_cnt - busy_base, 0);
    check("t3_wr_count", wq.size() - base, 0);
    check("t3_rd_addr", rd_addr, 8'h01);

    // 4: pointer set, repeated start, two-byte read
    i2c_start();
    write_byte(8'h72, ack); check("t4_ack_dev", ack, 1);
    write_byte(8'h98, ack); check("t4_ack_reg", ack, 1);
    check("t4_rd_addr0", rd_addr, 8'h98);
    i2c_start();
    write_byte(8'h73, ack); check("t4_ack_rd", ack, 1);
    check("t4_busy", busy, 1);
    read_byte(1'b0, rd); check("t4_rd0", rd, 8'h03);
    check("t4_rd_addr1", rd_addr, 8'h99);
    read_byte(1'b1, rd); check("t4_rd1", rd, 8'h5A);
    check("t4_rd_addr2", rd_addr, 8'h9A);
    check("t4_sda_released", sda_oe, 0);
    check("t4_busy_end", busy, 0);
    i2c_stop(); tick(4);

    // 5: STOP inside a data byte, then a normal write
    base = wq.size();
    i2c_start();
    write_byte(8'h72, ack); check("t5_ack_dev", ack, 1);
    write_byte(8'h50, ack); check("t5_ack_reg", ack, 1);
    send_bits(8'hA0, 4);
    i2c_stop(); tick(4);
    check("t5_no_wr", wq.size() - base, 0);
    check("t5_busy", busy, 0);
    i2c_start();
    write_byte(8'h72, ack); check("t5b_ack_dev", ack, 1);
    write_byte(8'h33, ack); check("t5b_ack_reg", ack, 1);
    write_byte(8'h44, ack); check("t5b_ack_data", ack, 1);
    i2c_stop(); tick(4);
    check("t5b_wr_count", wq.size() - base, 1);
    if (wq.size() > base) check("t5b_wr0", wq[base], 16'h3344);
    check("t5b_rd_addr", rd_addr, 8'h34);

    // 6: reset while the target drives a zero bit of a read byte (D5, bit 5)
    i2c_start();
    write_byte(8'h72, ack);
    write_byte(8'h20, ack);
    i2c_start();
    write_byte(8'h73, ack); check("t6_ack_rd", ack, 1);
    for (int i = 0; i < 2; i++) begin
      tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0;
    end
    tick(Q);
    check("t6_driving_bit5", sda_oe, 1);
    reset = 1'b1;
    scl_m = 1'b1; sda_m = 1'b1;
    @(posedge clk); #1;
    check("t6_sda_oe", sda_oe, 0);
    check("t6_wr_valid", wr_valid, 0);
    check("t6_wr_addr", wr_addr, 0);
    check("t6_wr_data", wr_data, 0);
    check("t6_rd_addr", rd_addr, 0);
    check("t6_busy", busy, 0);
    tick(3);
    reset = 1'b0;
    tick(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
